intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Machine-level interrupt source block, directly upstream of the trap/CSR unit.
- Contains a memory-mapped 64-bit machine timer (mtime/mtimecmp), a software interrupt bit (msip) and NUM_EXT external interrupt lines with per-line enable and per-line edge/level mode.
- Drives the single level `intr` input of the trap unit, which takes the rising edge when mstatus.MIE is set.
- Also reports the winning cause code.

Parameters:
- NUM_EXT, 4, number of external interrupt inputs (1..16).
- TIME_DIV, 1, clk cycles per mtime increment (>=1).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- ext_irq  in  NUM_EXT  asynchronous external interrupt requests.
- bus_en  in  1  register access strobe, single cycle.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  8  byte address; bits [1:0] are ignored.
- bus_wdat  in  32  write data.
- bus_rdat  out  32  read data, valid the cycle after a read strobe.
- intr  out  1  registered interrupt request to the trap unit.
- intr_cause  out  5  cause code for the highest-priority pending source; 0 when intr=0.
- mtime_o  out  64  current mtime, for trace/debug.

Behaviour:
- Reset values:
  - All outputs are 0.
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - msip = 0, ext_en = 0, ext_edge = 0, ext_pend = 0.
  - Prescaler = 0, both sync stages = 0.
- Register map (offsets):
  - 0x00 mtime_lo, RW.
  - 0x04 mtime_hi, RW.
  - 0x08 mtimecmp_lo, RW.
  - 0x0C mtimecmp_hi, RW.
  - 0x10 msip, bit0, RW.
  - 0x14 ext_en, RW.
  - 0x18 ext_pend, R; write-1-to-clear.
  - 0x1C ext_edge, RW; 1 = edge, 0 = level.
  - Unmapped offsets read 0; writes to them are ignored.
  - Bits at or above NUM_EXT read 0.
- Read timing:
  - bus_rdat is registered and holds the read value for one cycle after bus_en & ~bus_we.
  - bus_rdat is 0 in every other cycle.
- Prescaler:
  - Counts 0..TIME_DIV-1.
  - mtime increments by 1 (64-bit, wraps 2^64-1 -> 0) in the cycle the prescaler wraps.
  - TIME_DIV=1 increments every cycle.
- mtime writes:
  - A bus write to a mtime half loads that half and suppresses the increment that cycle for the whole 64-bit value.
  - Carry from lo into hi applies only on increment cycles.
- Timer pending: mtip = (mtime >= mtimecmp), unsigned 64-bit, combinational from the registers.
- External sync: ext_irq passes a 2-flop synchronizer, giving sync[i].
- Edge lines (ext_edge[i]=1):
  - Rising edge of sync[i] sets pend[i].
  - W1C clears pend[i].
  - Simultaneous set and clear: set wins.
- Level lines (ext_edge[i]=0):
  - pend[i] = sync[i] each cycle; W1C has no effect.
  - Switching a line edge -> level reloads pend from sync next cycle.
  - Switching level -> edge clears pend and waits for a new rising edge.
- Request and priority:
  - meip = |(pend & ext_en).
  - Fixed priority: meip (cause 11) > msip (cause 3) > mtip (cause 7).
  - intr and intr_cause are registered from these terms: 1 cycle latency from pend/mtip/msip change to output.
- Latency chain: async ext_irq rising to intr high is 3 clk (2 sync stages + 1 output register).
- Dropping and re-asserting:
  - intr stays high while any source is pending.
  - Software drops it by clearing msip, W1C on pend, or writing mtimecmp above mtime.
  - Cause changes without intr dropping are allowed; the trap unit samples only on the rising edge.
- Reset mid-operation clears all state in the same cycle, including pending and in-flight read data.

Optional Feature:
- Macro INTR_CTRL_CLAIM_EN.
- When defined:
  - Adds a claim register at 0x20.
  - A read returns the lowest-index pending & enabled external line as index+1, or 0 if none.
  - The same read clears pend for that line if it is edge-mode; level-mode lines are unaffected.
  - A claim read cycle counts as a W1C for priority purposes: a set in the same cycle wins.
- When undefined: 0x20 is unmapped and reads 0.

Test Plan:
- Reset, then read 0x08 and 0x0C -> 0xFFFFFFFF each; intr=0; intr_cause=0.
- TIME_DIV=1: write mtimecmp_lo=20, mtimecmp_hi=0 -> mtime reaches 20 at cycle 20 after reset release, intr=1 with cause=7 one cycle later.
- Write mtime_lo=0xFFFFFFFF, mtime_hi=0 -> next increment gives hi=1, lo=0; a write in the same cycle as an increment holds the written value.
- ext_en=0x1, ext_edge=0x1, pulse ext_irq[0] for 1 cycle -> pend=0x1, intr=1 with cause=11 3 cycles after the pulse. Then W1C 0x18=0x1 -> intr=0 next cycle. Repeat with the pulse landing on the W1C cycle -> pend stays 1.
- msip=1 with mtip active -> cause=3. Then set ext_en with a level line high -> cause=11. Clear all sources -> intr=0, cause=0.
- INTR_CTRL_CLAIM_EN: lines 1 and 2 edge-pending and enabled -> reading 0x20 returns 2 and clears pend[1]; a second read returns 3; a third read returns 0.

Source files
------------

// File: rtl/intr_ctrl.sv
// Machine interrupt source: mtime/mtimecmp timer, msip, NUM_EXT synced external lines; optional claim reg (INTR_CTRL_CLAIM_EN).
// Latency: intr/intr_cause 1 clk after source change, ext_irq->intr 3 clk; bus_rdat 1 clk after read strobe.
// Backpressure: none, bus accesses always complete in a single cycle.
module intr_ctrl #(
  parameter int NUM_EXT  = 4,
  parameter int TIME_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               bus_en,
  input  logic               bus_we,
  input  logic [7:0]         bus_addr,
  input  logic [31:0]        bus_wdat,
  output logic [31:0]        bus_rdat,
  output logic               intr,
  output logic [4:0]         intr_cause,
  output logic [63:0]        mtime_o
);

  localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TIME_DIV - 1);

  logic [PW-1:0]      presc;
  logic               tick;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               msip;
  logic [NUM_EXT-1:0] ext_en;
  logic [NUM_EXT-1:0] ext_edge;
  logic [NUM_EXT-1:0] ext_pend;
  logic [NUM_EXT-1:0] sync1;
  logic [NUM_EXT-1:0] sync2;
  logic [NUM_EXT-1:0] rise;
  logic [NUM_EXT-1:0] wr_clr;
  logic [NUM_EXT-1:0] pend_clr;
  logic [NUM_EXT-1:0] edge_nxt;
  logic [NUM_EXT-1:0] pend_nxt;
  logic [5:0]         widx;
  logic               wr;
  logic               rd;
  logic               mtip;
  logic               meip;
  logic [31:0]        rdata;
  logic               unused_addr;

  assign wr          = bus_en & bus_we;
  assign rd          = bus_en & ~bus_we;
  assign widx        = bus_addr[7:2];
  assign unused_addr = ^bus_addr[1:0];
  assign tick        = (presc == PMAX);

  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // A write to either half freezes the whole counter for that cycle.
  always_ff @(posedge clk) begin
    if (rst)                         mtime         <= '0;
    else if (wr && widx == 6'h00)    mtime[31:0]   <= bus_wdat;
    else if (wr && widx == 6'h01)    mtime[63:32]  <= bus_wdat;
    else if (tick)                   mtime         <= mtime + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
      ext_en   <= '0;
      ext_edge <= '0;
    end else if (wr) begin
      case (widx)
        6'h02:   mtimecmp[31:0]  <= bus_wdat;
        6'h03:   mtimecmp[63:32] <= bus_wdat;
        6'h04:   msip            <= bus_wdat[0];
        6'h05:   ext_en          <= bus_wdat[NUM_EXT-1:0];
        6'h07:   ext_edge        <= bus_wdat[NUM_EXT-1:0];
        default: ;
      endcase
    end
  end

  assign wr_clr   = (wr && widx == 6'h06) ? bus_wdat[NUM_EXT-1:0] : '0;
  assign edge_nxt = (wr && widx == 6'h07) ? bus_wdat[NUM_EXT-1:0] : ext_edge;
  assign rise     = sync1 & ~sync2;

`ifdef INTR_CTRL_CLAIM_EN
  logic [NUM_EXT-1:0] claim_clr;
  logic [4:0]         claim_id;

  // Descending scan so the lowest-index pending line is the one left standing.
  always_comb begin
    claim_id  = '0;
    claim_clr = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (ext_pend[i] && ext_en[i]) begin
        claim_id     = 5'(i + 1);
        claim_clr    = '0;
        claim_clr[i] = 1'b1;
      end
    end
    if (!(rd && widx == 6'h08)) claim_clr = '0;
  end

  assign pend_clr = wr_clr | claim_clr;
`else
  assign pend_clr = wr_clr;
`endif

  // Level lines load sync1 so pend equals the synchronised level in the same cycle.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (!edge_nxt[i])      pend_nxt[i] = sync1[i];
      else if (!ext_edge[i]) pend_nxt[i] = rise[i];
      else                   pend_nxt[i] = rise[i] | (ext_pend[i] & ~pend_clr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      ext_pend <= '0;
    end else begin
      sync1    <= ext_irq;
      sync2    <= sync1;
      ext_pend <= pend_nxt;
    end
  end

  assign mtip = (mtime >= mtimecmp);
  assign meip = |(ext_pend & ext_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      intr       <= 1'b0;
      intr_cause <= 5'd0;
    end else begin
      intr <= meip | msip | mtip;
      if (meip)      intr_cause <= 5'd11;
      else if (msip) intr_cause <= 5'd3;
      else if (mtip) intr_cause <= 5'd7;
      else           intr_cause <= 5'd0;
    end
  end

  always_comb begin
    rdata = '0;
    case (widx)
      6'h00:   rdata = mtime[31:0];
      6'h01:   rdata = mtime[63:32];
      6'h02:   rdata = mtimecmp[31:0];
      6'h03:   rdata = mtimecmp[63:32];
      6'h04:   rdata = {31'd0, msip};
      6'h05:   rdata = 32'(ext_en);
      6'h06:   rdata = 32'(ext_pend);
      6'h07:   rdata = 32'(ext_edge);
`ifdef INTR_CTRL_CLAIM_EN
      6'h08:   rdata = 32'(claim_id);
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     bus_rdat <= '0;
    else if (rd) bus_rdat <= rdata;
    else         bus_rdat <= '0;
  end

  assign mtime_o = mtime;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl (NUM_EXT=4, TIME_DIV=1); claim checks follow INTR_CTRL_CLAIM_EN.
module tb_intr_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  ext_irq;
  logic        bus_en;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdat;
  logic [31:0] bus_rdat;
  logic        intr;
  logic [4:0]  intr_cause;
  logic [63:0] mtime_o;

  int tests = 0;
  int fails = 0;

  // Timer model: mtime is the last loaded value plus the clocks elapsed since.
  logic [63:0] ncyc;
  logic [63:0] mt_base;
  logic [63:0] mt_base_cyc;

  intr_ctrl #(.NUM_EXT(4), .TIME_DIV(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_irq    (ext_irq),
    .bus_en     (bus_en),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdat   (bus_wdat),
    .bus_rdat   (bus_rdat),
    .intr       (intr),
    .intr_cause (intr_cause),
    .mtime_o    (mtime_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) ncyc <= 64'd0;
    else     ncyc <= ncyc + 64'd1;
  end

  function automatic logic [63:0] m_mtime();
    return mt_base + (ncyc - mt_base_cyc);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdat = d;
    step();
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    step();
    d = bus_rdat;
    bus_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; ext_irq = '0; bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdat = '0;
    step(); step(); step();
    tests++; if (intr !== 1'b0) begin fails++; $display("FAIL reset_intr: got %b want 0", intr); end
    tests++; if (intr_cause !== 5'd0) begin fails++; $display("FAIL reset_cause: got %0d want 0", intr_cause); end
    tests++; if (mtime_o !== 64'd0) begin fails++; $display("FAIL reset_mtime: got %h want 0", mtime_o); end
    tests++; if (bus_rdat !== 32'd0) begin fails++; $display("FAIL reset_rdat: got %h want 0", bus_rdat); end
    rst = 1'b0;
    mt_base = 64'd0; mt_base_cyc = 64'd0;
    bus_read(8'h08, d);
    tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_cmp_lo: got %h want ffffffff", d); end
    bus_read(8'h0C, d);
    tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_cmp_hi: got %h want ffffffff", d); end
  endtask

  task automatic test_timer_cmp();
    logic [31:0] d;
    logic [63:0] exp;
    bus_write(8'h08, 32'd20);
    bus_write(8'h0C, 32'd0);
    exp = m_mtime();
    bus_read(8'h00, d);
    tests++; if (d !== exp[31:0]) begin fails++; $display("FAIL mtime_lo_read: got %h want %h", d, exp[31:0]); end
    for (int g = 0; g < 100 && ncyc < 64'd20; g++) step();
    tests++; if (ncyc !== 64'd20) begin fails++; $display("FAIL timer_wait_timeout: got %0d want 20", ncyc); end
    tests++; if (mtime_o !== 64'd20) begin fails++; $display("FAIL mtime_at_20: got %0d want 20", mtime_o); end
    tests++; if (intr !== 1'b0) begin fails++; $display("FAIL timer_intr_early: got %b want 0", intr); end
    step();
    tests++; if (intr !== 1'b1 || intr_cause !== 5'd7) begin
      fails++; $display("FAIL timer_intr: got intr=%b cause=%0d want 1/7", intr, intr_cause); end
  endtask

  task automatic test_mtime_carry();
    logic [31:0] d;
    bus_write(8'h00, 32'hFFFF_FFFF);
    bus_write(8'h04, 32'd0);
    tests++; if (mtime_o !== 64'h0000_0000_FFFF_FFFF) begin
      fails++; $display("FAIL mtime_write_hold: got %h want 00000000ffffffff", mtime_o); end
    step();
    tests++; if (mtime_o !== 64'h0000_0001_0000_0000) begin
      fails++; $display("FAIL mtime_carry: got %h want 0000000100000000", mtime_o); end
    mt_base = 64'h0000_0001_0000_0000; mt_base_cyc = ncyc;
    tests++; if (intr !== 1'b1 || intr_cause !== 5'd7) begin
      fails++; $display("FAIL carry_intr: got intr=%b cause=%0d want 1/7", intr, intr_cause); end
    bus_read(8'h04, d);
    tests++; if (d !== 32'd1) begin fails++; $display("FAIL mtime_hi_read: got %h want 1", d); end
    bus_write(8'h0C, 32'hFFFF_FFFF);
    step();
    tests++; if (intr !== 1'b0 || intr_cause !== 5'd0) begin
      fails++; $display("FAIL timer_drop: got intr=%b cause=%0d want 0/0", intr, intr_cause); end
  endtask

  task automatic test_edge_ext();
    logic [31:0] d;
    bus_write(8'h14, 32'h1);
    bus_write(8'h1C, 32'h1);
    ext_irq = 4'b0001;
    step();
    ext_irq = 4'b0000;
    tests++; if (intr !== 1'b0) begin fails++; $display("FAIL edge_intr_c1: got %b want 0", intr); end
    step();
    tests++; if (intr !== 1'b0) begin fails++; $display("FAIL edge_intr_c2: got %b want 0", intr); end
    step();
    tests++; if (intr !== 1'b1 || intr_cause !== 5'd11) begin
      fails++; $display("FAIL edge_intr_c3: got intr=%b cause=%0d want 1/11", intr, intr_cause); end
    bus_read(8'h18, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL edge_pend: got %h want 1", d); end
    bus_write(8'h18, 32'h1);
    step();
    tests++; if (intr !== 1'b0) begin fails++; $display("FAIL w1c_drop: got %b want 0", intr); end
    // Rising edge reaches the pend logic on the same clock as the W1C.
    ext_irq = 4'b0001;
    step();
    ext_irq = 4'b0000;
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = 8'h18; bus_wdat = 32'h1;
    step();
    bus_en = 1'b0; bus_we = 1'b0;
    step();
    tests++; if (intr !== 1'b1) begin fails++; $display("FAIL set_wins_intr: got %b want 1", intr); end
    bus_read(8'h18, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL set_wins_pend: got %h want 1", d); end
    bus_write(8'h18, 32'h1);
    bus_read(8'h18, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL w1c_pend: got %h want 0", d); end
  endtask

  task automatic test_priority();
    bus_write(8'h0C, 32'd0);
    bus_write(8'h10, 32'd1);
    step();
    tests++; if (intr !== 1'b1 || intr_cause !== 5'd3) begin
      fails++; $display("FAIL prio_msip: got intr=%b cause=%0d want 1/3", intr, intr_cause); end
    bus_write(8'h1C, 32'h0);
    ext_irq = 4'b0010;
    bus_write(8'h14, 32'h2);
    step(); step();
    tests++; if (intr !== 1'b1 || intr_cause !== 5'd11) begin
      fails++; $display("FAIL prio_meip: got intr=%b cause=%0d want 1/11", intr, intr_cause); end
    ext_irq = 4'b0000;
    bus_write(8'h14, 32'h0);
    bus_write(8'h10, 32'h0);
    bus_write(8'h0C, 32'hFFFF_FFFF);
    step(); step();
    tests++; if (intr !== 1'b0 || intr_cause !== 5'd0) begin
      fails++; $display("FAIL prio_clear: got intr=%b cause=%0d want 0/0", intr, intr_cause); end
  endtask

  task automatic test_bus_misc();
    logic [31:0] d;
    bus_read(8'h10, d);
    step();
    tests++; if (bus_rdat !== 32'd0) begin fails++; $display("FAIL rdat_idle: got %h want 0", bus_rdat); end
    bus_write(8'h24, 32'hFFFF_FFFF);
    bus_read(8'h24, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL unmapped_read: got %h want 0", d); end
    bus_read(8'h10, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL unmapped_write: got %h want 0", d); end
    bus_write(8'h14, 32'hFFFF_FFFF);
    bus_read(8'h15, d);
    tests++; if (d !== 32'hF) begin fails++; $display("FAIL en_width: got %h want f", d); end
    bus_write(8'h14, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [63:0] exp;
    logic [3:0]  p;
    logic [3:0]  en;
    logic        ms;
    logic        tm;
    logic [31:0] cmp_hi;
    logic        mtip_e;
    logic [4:0]  cause_e;
    for (int it = 0; it < 16; it++) begin
      p      = 4'($urandom_range(0, 15));
      en     = 4'($urandom_range(0, 15));
      ms     = 1'($urandom_range(0, 1));
      tm     = 1'($urandom_range(0, 1));
      cmp_hi = tm ? 32'd0 : 32'hFFFF_FFFF;
      ext_irq = p;
      bus_write(8'h14, {28'd0, en});
      bus_write(8'h10, {31'd0, ms});
      bus_write(8'h0C, cmp_hi);
      step(); step();
      exp = m_mtime();
      bus_read(8'h00, d);
      tests++; if (d !== exp[31:0]) begin fails++; $display("FAIL rnd_mtime it%0d: got %h want %h", it, d, exp[31:0]); end
      bus_read(8'h18, d);
      tests++; if (d !== {28'd0, p}) begin fails++; $display("FAIL rnd_pend it%0d: got %h want %h", it, d, p); end
      mtip_e = (m_mtime() >= {cmp_hi, 32'd20});
      if ((p & en) != 4'd0) cause_e = 5'd11;
      else if (ms)          cause_e = 5'd3;
      else if (mtip_e)      cause_e = 5'd7;
      else                  cause_e = 5'd0;
      tests++; if (intr !== (cause_e != 5'd0) || intr_cause !== cause_e) begin
        fails++; $display("FAIL rnd_intr it%0d: got intr=%b cause=%0d want cause=%0d", it, intr, intr_cause, cause_e); end
    end
    ext_irq = 4'b0000;
    bus_write(8'h14, 32'h0);
    bus_write(8'h10, 32'h0);
    bus_write(8'h0C, 32'hFFFF_FFFF);
  endtask

  task automatic test_claim();
    logic [31:0] d;
    step(); step();
`ifdef INTR_CTRL_CLAIM_EN
    bus_write(8'h14, 32'h6);
    bus_write(8'h1C, 32'h6);
    ext_irq = 4'b0110;
    step();
    ext_irq = 4'b0000;
    step(); step();
    bus_read(8'h20, d);
    tests++; if (d !== 32'd2) begin fails++; $display("FAIL claim_first: got %0d want 2", d); end
    bus_read(8'h18, d);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL claim_pend: got %h want 4", d); end
    bus_read(8'h20, d);
    tests++; if (d !== 32'd3) begin fails++; $display("FAIL claim_second: got %0d want 3", d); end
    bus_read(8'h20, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL claim_empty: got %0d want 0", d); end
    bus_write(8'h14, 32'h0);
`else
    bus_read(8'h20, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL claim_unmapped: got %h want 0", d); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(8'h10, 32'd1);
    step();
    tests++; if (intr !== 1'b1) begin fails++; $display("FAIL mid_pre_intr: got %b want 1", intr); end
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = 8'h10; rst = 1'b1;
    step();
    bus_en = 1'b0; rst = 1'b0;
    mt_base = 64'd0; mt_base_cyc = 64'd0;
    tests++; if (bus_rdat !== 32'd0) begin fails++; $display("FAIL mid_rdat: got %h want 0", bus_rdat); end
    tests++; if (intr !== 1'b0 || intr_cause !== 5'd0) begin
      fails++; $display("FAIL mid_intr: got intr=%b cause=%0d want 0/0", intr, intr_cause); end
    tests++; if (mtime_o !== 64'd0) begin fails++; $display("FAIL mid_mtime: got %h want 0", mtime_o); end
    bus_read(8'h10, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL mid_msip: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_timer_cmp();
    test_mtime_carry();
    test_edge_ext();
    test_priority();
    test_bus_misc();
    test_random();
    test_claim();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
